// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Holds FSM states, read-select encodings, op codes and the iteration count.
package hilo_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULTU = 1'b0,
        OP_DIVU  = 1'b1
    } op_t;

    localparam logic [1:0] LH_NONE = 2'b00;
    localparam logic [1:0] LH_LO   = 2'b01;
    localparam logic [1:0] LH_HI   = 2'b10;

    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

endpackage

// File: rtl/hilo_muldiv_unit_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring divide.
// result is the value the registers take after the current step.
module muldiv_iter_core
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  op_t                op,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   m;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH:0]     div_rem_nxt;
    logic [WIDTH-1:0]   div_q_nxt;

    // Multiply: multiplier sits in acc low half and is consumed LSB first.
    // Divide: acc low half starts as the dividend and fills with quotient bits.
    always_comb begin
        mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        mul_nxt     = {mul_sum, acc[WIDTH-1:1]};
        div_sh      = {rem[WIDTH-1:0], acc[WIDTH-1]};
        div_diff    = div_sh - {1'b0, m};
        div_ok      = ~div_diff[WIDTH];
        div_rem_nxt = div_ok ? div_diff : div_sh;
        div_q_nxt   = {acc[WIDTH-2:0], div_ok};
        result      = (op == OP_MULTU) ? mul_nxt : {div_rem_nxt[WIDTH-1:0], div_q_nxt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            rem <= '0;
            m   <= '0;
        end else if (load) begin
            rem <= '0;
            if (op == OP_MULTU) begin
                acc <= {{WIDTH{1'b0}}, b};
                m   <= a;
            end else begin
                acc <= {{WIDTH{1'b0}}, a};
                m   <= b;
            end
        end else if (step) begin
            if (op == OP_MULTU) begin
                acc <= mul_nxt;
            end else begin
                acc <= {{WIDTH{1'b0}}, div_q_nxt};
                rem <= div_rem_nxt;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULTU/DIVU unit owning the architectural HI/LO registers.
// Stalls the datapath while running; HI/LO update only when a run completes.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartMultu,
    input  logic             StartDivu,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       LHToReg,
    output logic [WIDTH-1:0] LHData,
    output logic             Stall,
    output logic             Busy,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_t             state;
    op_t                op_q;
    logic [CNT_W-1:0]   cnt;
    logic               start;
    logic               accept;
    op_t                start_op;
    op_t                core_op;
    logic [2*WIDTH-1:0] result;

    assign start    = StartMultu | StartDivu;
    assign start_op = StartMultu ? OP_MULTU : OP_DIVU;
    assign accept   = (state == S_IDLE) && start;
    // The load must see the incoming op; steps use the latched one.
    assign core_op  = accept ? start_op : op_q;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .op     (core_op),
        .load   (accept),
        .step   (state == S_RUN),
        .a      (A),
        .b      (B),
        .result (result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= OP_MULTU;
            cnt   <= '0;
            Hi    <= '0;
            Lo    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_q  <= start_op;
                    cnt   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITERS - 1)) begin
                        Hi    <= result[2*WIDTH-1:WIDTH];
                        Lo    <= result[WIDTH-1:0];
                        state <= S_DONE;
                    end
                end
                // DONE ignores starts so the held instruction can retire.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Busy  = (state == S_RUN);
    assign Stall = accept | Busy;

    always_comb begin
        LHData = '0;
        case (LHToReg)
            LH_LO:   LHData = Lo;
            LH_HI:   LHData = Hi;
            default: LHData = '0;
        endcase
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases plus random
// MULTU/DIVU runs checked against plain 64-bit arithmetic.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        StartMultu, StartDivu;
    logic [31:0] A, B;
    logic [1:0]  LHToReg;
    logic [31:0] LHData, Hi, Lo;
    logic        Stall, Busy;

    int errors = 0;
    int checks = 0;
    int pc = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .StartMultu(StartMultu), .StartDivu(StartDivu),
        .A(A), .B(B), .LHToReg(LHToReg), .LHData(LHData), .Stall(Stall),
        .Busy(Busy), .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    // Instruction fetch model: PC advances on every unstalled cycle.
    always @(posedge clk) if (!Stall) pc <= pc + 1;

    function automatic logic [63:0] model(input logic is_mul, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (is_mul) r = {32'd0, a} * {32'd0, b};
        else if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
        return r;
    endfunction

    // Starts an op at a negedge, scrambles operands during RUN, and returns
    // in the DONE cycle (mid-low phase) with the start still asserted.
    task automatic run_op(input logic sm, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, output int stalls);
        @(negedge clk);
        StartMultu = sm; StartDivu = sd; A = a; B = b;
        #1;
        stalls = 0;
        while (Stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
            A = $urandom; B = $urandom;
            #1;
        end
    endtask

    task automatic check_result(input string name, input logic [63:0] exp, input int stalls);
        checks++;
        if (stalls !== 33) begin
            errors++; $display("FAIL %s stall_cycles got=%0d want=33", name, stalls);
        end
        checks++;
        if ({Hi, Lo} !== exp) begin
            errors++; $display("FAIL %s hilo got=%h_%h want=%h", name, Hi, Lo, exp);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL %s busy_in_done got=%b want=0", name, Busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; StartMultu = 0; StartDivu = 0; A = '0; B = '0; LHToReg = LH_LO_C();
        #12;
        checks++;
        if ({Hi, Lo, Stall, Busy, LHData} !== '0) begin
            errors++; $display("FAIL reset_state got hi=%h lo=%h stall=%b busy=%b lh=%h want all 0",
                               Hi, Lo, Stall, Busy, LHData);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    function automatic logic [1:0] LH_LO_C(); return 2'b01; endfunction

    task automatic test_multu_max();
        int s;
        run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
        StartMultu = 0;
        check_result("multu_max", 64'hFFFF_FFFE_0000_0001, s);
    endtask

    task automatic test_divu();
        int s;
        run_op(0, 1, 32'd100, 32'd7, s);
        StartDivu = 0; LHToReg = 2'b01; #1;
        check_result("divu_100_7", {32'd2, 32'd14}, s);
        checks++;
        if (LHData !== 32'd14) begin
            errors++; $display("FAIL mflo_in_done got=%0d want=14", LHData);
        end
    endtask

    task automatic test_div0();
        int s;
        run_op(0, 1, 32'h1234_5678, 32'd0, s);
        StartDivu = 0;
        check_result("divu_by_zero", model(0, 32'h1234_5678, 0), s);
    endtask

    task automatic test_back_to_back();
        int s, p0;
        run_op(0, 1, 32'd100, 32'd7, s);
        check_result("held_first", {32'd2, 32'd14}, s);
        checks++;
        if (Stall !== 1'b0) begin
            errors++; $display("FAIL held_done_stall got=%b want=0", Stall);
        end
        p0 = pc;
        A = 32'd50; B = 32'd8;
        @(negedge clk); #1;
        checks++;
        if (pc !== p0 + 1 || Stall !== 1'b1) begin
            errors++; $display("FAIL held_restart got pc_delta=%0d stall=%b want 1/1", pc - p0, Stall);
        end
        @(negedge clk); StartDivu = 0; #1;
        s = 0;
        while (Busy && s < 100) begin s++; @(negedge clk); #1; end
        checks++;
        if ({Hi, Lo} !== model(0, 50, 8)) begin
            errors++; $display("FAIL held_second got=%h_%h want=%h", Hi, Lo, model(0, 50, 8));
        end
    endtask

    task automatic test_both_starts();
        int s;
        run_op(1, 1, 32'd6, 32'd3, s);
        StartMultu = 0; StartDivu = 0;
        check_result("both_multu_wins", {32'd0, 32'd18}, s);
    endtask

    task automatic test_reset_mid();
        int s;
        @(negedge clk);
        StartMultu = 1; A = 5; B = 5;
        repeat (11) @(negedge clk);
        checks++;
        if (Busy !== 1'b1) begin
            errors++; $display("FAIL midrun_busy got=%b want=1", Busy);
        end
        #2; StartMultu = 0; rst = 1'b1; #1;
        checks++;
        if ({Hi, Lo, Stall, Busy} !== '0) begin
            errors++; $display("FAIL midrun_reset got hi=%h lo=%h stall=%b busy=%b want 0",
                               Hi, Lo, Stall, Busy);
        end
        @(negedge clk); rst = 1'b0;
        run_op(1, 0, 32'd5, 32'd5, s);
        StartMultu = 0;
        check_result("after_reset_multu", 64'd25, s);
    endtask

    task automatic test_lh_select();
        int s;
        run_op(0, 1, 32'd23, 32'd5, s);
        StartDivu = 0;
        @(negedge clk);
        LHToReg = 2'b11; #1;
        checks++;
        if (LHData !== 32'd0 || Stall !== 1'b0) begin
            errors++; $display("FAIL lh_none got lh=%h stall=%b want 0/0", LHData, Stall);
        end
        LHToReg = 2'b10; #1;
        checks++;
        if (LHData !== 32'd3) begin
            errors++; $display("FAIL mfhi got=%0d want=3", LHData);
        end
        LHToReg = 2'b01; #1;
        checks++;
        if (LHData !== 32'd4) begin
            errors++; $display("FAIL mflo got=%0d want=4", LHData);
        end
        LHToReg = 2'b00;
    endtask

    task automatic test_random();
        int s;
        logic is_mul;
        logic [31:0] a, b;
        for (int i = 0; i < 20; i++) begin
            is_mul = $urandom_range(0, 1) == 1;
            a = $urandom;
            b = (i % 5 == 4) ? 32'd0 : (i % 3 == 0 ? ($urandom & 32'hFF) : $urandom);
            run_op(is_mul, ~is_mul, a, b, s);
            StartMultu = 0; StartDivu = 0;
            check_result(is_mul ? "rand_multu" : "rand_divu", model(is_mul, a, b), s);
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_divu();
        test_div0();
        test_back_to_back();
        test_both_starts();
        test_reset_mid();
        test_lh_select();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative unsigned multiply/divide unit with the architectural HI/LO registers. It sits directly downstream of the instruction controller and consumes the decoded MULTU/DIVU start strobes and the MFHI/MFLO read select. It stalls the single-cycle datapath while an operation runs and supplies HI or LO to the register-file write-back mux.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `StartMultu`  in  1  current instruction is MULTU.
- `StartDivu`  in  1  current instruction is DIVU.
- `A`  in  WIDTH  REG[Rs], dividend or multiplicand.
- `B`  in  WIDTH  REG[Rt], divisor or multiplier.
- `LHToReg`  in  2  read select: 01 = LO, 10 = HI, 00 or 11 = none.
- `LHData`  out  WIDTH  selected HI/LO value. 0 when the select is none.
- `Stall`  out  1  hold PC and suppress register/memory writes this cycle.
- `Busy`  out  1  state is RUN.
- `Hi`, `Lo`  out  WIDTH  architectural registers, for debug display.

## Operation
- States: IDLE, RUN, DONE. A 5-bit iteration counter runs in RUN.
- In IDLE, a start is accepted when `StartMultu | StartDivu`. If both are high, MULTU wins.
  - On acceptance, latch A and B, latch the op, clear the counter and go to RUN.
- RUN lasts exactly 32 cycles (counter 0..31). At counter 31, write the result into HI/LO and go to DONE.
- MULTU uses shift-add over a 64-bit accumulator.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper 33 bits, then shift the accumulator right by 1.
  - Result: HI = product[63:32], LO = product[31:0], unsigned, no overflow.
- DIVU uses restoring division with a 33-bit partial remainder.
  - Each cycle: shift {rem, quot} left by 1, trial-subtract the divisor; if non-negative, keep the difference and set the quotient LSB.
  - Result: LO = quotient, HI = remainder.
- DIVU with B = 0 still takes 32 cycles and gives LO = 0xFFFFFFFF, HI = A. No exception is raised.
- DONE lasts one cycle, then returns to IDLE. Starts are ignored in DONE.
  - This lets the held MULTU/DIVU instruction retire without re-triggering.
- HI/LO change only at RUN completion or reset. A start never corrupts HI/LO mid-operation.
- `Stall` = (IDLE & (StartMultu | StartDivu)) | RUN | (RUN & LHToReg != 00).
- `LHData` is combinational from the HI/LO registers and `LHToReg`.

## Timing
- Reset (async, immediate) forces HI = LO = 0, state IDLE, counter 0, `Stall` = 0, `Busy` = 0, `LHData` = 0.
- Reset in RUN aborts the operation. HI/LO go to 0, not to a partial result.
- Start sampled at edge E0. RUN covers E0..E31. HI/LO are valid after E32. DONE runs E32..E33. IDLE from E33.
- A MULTU/DIVU instruction occupies 34 cycles: 33 stalled plus 1 in DONE.
- An MFHI/MFLO in the DONE cycle or later sees the new value. There is no forwarding of partial results.
- Operands are captured at acceptance. A and B may change during RUN without effect.

## Structure
- The shared package holds:
  - the state enum (IDLE/RUN/DONE);
  - the `LHToReg` encodings LH_NONE = 00, LH_LO = 01, LH_HI = 10;
  - the op enum (OP_MULTU/OP_DIVU);
  - the iteration count constant 32.
- One sub-module, `muldiv_iter_core`, holds the accumulator/remainder datapath and one-step logic. It has inputs `op`, `load`, `step`, and outputs a 64-bit result.
- The FSM, counter and HI/LO registers stay in `hilo_muldiv_unit`.

## Test plan
- MULTU, A = 0xFFFFFFFF, B = 0xFFFFFFFF: `Stall` high for 33 cycles, then HI = 0xFFFFFFFE, LO = 0x00000001.
- DIVU, A = 100, B = 7: LO = 14, HI = 2 after E32; MFLO in DONE returns 14 on `LHData`.
- DIVU, A = 0x12345678, B = 0: LO = 0xFFFFFFFF, HI = 0x12345678.
- Start held through DONE into IDLE: exactly one operation in DONE; a start still high at IDLE starts a second run, and the bench checks the PC advanced.
  - StartMultu and StartDivu both high with A = 6, B = 3: result HI = 0, LO = 18 (MULTU wins).
- `rst` pulsed at RUN cycle 10 of MULTU 5×5: HI = LO = 0, `Stall` = 0 immediately. A following MULTU 5×5 gives LO = 25.
- `LHToReg` = 11 in IDLE with HI = 3, LO = 4: `LHData` = 0, `Stall` = 0.
